// File: rtl/latch_write_sequencer_if.sv
// Handshake and latch-side signals of the latch write sequencer.
// The master drives words and latch readback; the slave is the sequencer.
interface latch_write_sequencer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] DATA_IN;
  logic             VALID;
  logic             READY;
  logic             EN;
  logic             D;
  logic             Q_IN;
  logic             BUSY;
  logic             DONE;
  logic             ERR;

  modport master (
    output DATA_IN, VALID, Q_IN,
    input  READY, EN, D, BUSY, DONE, ERR
  );

  modport slave (
    input  DATA_IN, VALID, Q_IN,
    output READY, EN, D, BUSY, DONE, ERR
  );
endinterface

// File: rtl/latch_write_sequencer.sv
// Serialises a parallel word MSB-first into a downstream D latch using a
// SETUP/STROBE/HOLD pattern per bit, and checks each bit via latch readback.
module latch_write_sequencer #(
  parameter int WIDTH = 8
) (
  input logic                    CLK,
  input logic                    RST_N,
  latch_write_sequencer_if.slave bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] FIN    = 3'd4;
  localparam int         IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             en_q, en_d;
  logic             d_q, d_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    err_d    = err_q;
    d_d      = d_q;
    case (state_q)
      IDLE: begin
        if (bus.VALID) begin
          shadow_d = bus.DATA_IN;
          err_d    = 1'b0;
          idx_d    = IW'(WIDTH - 1);
          state_d  = SETUP;
        end
      end
      SETUP:  state_d = STROBE;
      STROBE: state_d = HOLD;
      HOLD: begin
        if (bus.Q_IN != shadow_q[idx_q]) err_d = 1'b1;
        if (idx_q == '0) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = SETUP;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    if (state_d == SETUP) d_d = shadow_d[idx_d];
    en_d    = (state_d == STROBE);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    done_d  = (state_d == FIN);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      en_q     <= 1'b0;
      d_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      en_q     <= en_d;
      d_q      <= d_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.READY = ready_q;
  assign bus.EN    = en_q;
  assign bus.D     = d_q;
  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;
  assign bus.ERR   = err_q;
endmodule

// File: tb/tb_latch_write_sequencer.sv
// Directed bench for latch_write_sequencer with a model D latch on Q_IN.
module tb_latch_write_sequencer;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic q_force0 = 1'b0;
  logic lat_q = 1'b0;
  int   errors = 0;
  int   checks = 0;

  latch_write_sequencer_if #(.WIDTH(8)) bus ();

  latch_write_sequencer #(.WIDTH(8)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(bus.EN or bus.D) if (bus.EN) lat_q = bus.D;
  assign bus.Q_IN = q_force0 ? 1'b0 : lat_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Accept one word and check every cycle up to the return to IDLE.
  task automatic run_word(input logic [7:0] dat, input logic force0,
                          input logic exp_err, input logic scramble);
    int en_cnt;
    int done_cnt;
    int bi;
    int ph;
    en_cnt   = 0;
    done_cnt = 0;
    @(negedge clk);
    chk("ready_pre", bus.READY, 1);
    bus.VALID   = 1'b1;
    bus.DATA_IN = dat;
    q_force0    = force0;
    @(posedge clk);
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      if (c <= 24) begin
        bi = 7 - (c - 1) / 3;
        ph = (c - 1) % 3;
        chk("en",    bus.EN,    (ph == 1) ? 1 : 0);
        chk("d",     bus.D,     dat[bi]);
        chk("busy",  bus.BUSY,  1);
        chk("ready", bus.READY, 0);
        chk("done",  bus.DONE,  0);
      end else if (c == 25) begin
        chk("fin_done",  bus.DONE,  1);
        chk("fin_busy",  bus.BUSY,  1);
        chk("fin_ready", bus.READY, 0);
        chk("fin_en",    bus.EN,    0);
        chk("fin_err",   bus.ERR,   exp_err);
      end else begin
        chk("idle_ready", bus.READY, 1);
        chk("idle_busy",  bus.BUSY,  0);
        chk("idle_done",  bus.DONE,  0);
        chk("idle_err",   bus.ERR,   exp_err);
      end
      if (c == 1) chk("err_clear", bus.ERR, 0);
      en_cnt   += int'(bus.EN);
      done_cnt += int'(bus.DONE);
      if (c == 1) begin
        bus.VALID = 1'b0;
        if (scramble) bus.DATA_IN = 8'h00;
      end
    end
    chk("en_pulses",  en_cnt,   8);
    chk("done_count", done_cnt, 1);
  endtask

  initial begin
    int en_cnt;
    int done_cnt;
    int spacing;
    bus.VALID   = 1'b1;
    bus.DATA_IN = 8'hFF;
    rst_n       = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.READY, 1);
    chk("rst_en",    bus.EN,    0);
    chk("rst_d",     bus.D,     0);
    chk("rst_busy",  bus.BUSY,  0);
    chk("rst_done",  bus.DONE,  0);
    chk("rst_err",   bus.ERR,   0);
    bus.VALID = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run_word(8'hA5, 1'b0, 1'b0, 1'b0);
    run_word(8'h3C, 1'b1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("err_sticky", bus.ERR, 1);
    q_force0 = 1'b0;
    run_word(8'hFF, 1'b0, 1'b0, 1'b1);

    // Reset during STROBE of bit 4 (cycle 11 after accept).
    @(negedge clk);
    bus.VALID   = 1'b1;
    bus.DATA_IN = 8'hA5;
    @(posedge clk);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) bus.VALID = 1'b0;
    end
    chk("strobe_b4", bus.EN, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_en",    bus.EN,    0);
    chk("abort_busy",  bus.BUSY,  0);
    chk("abort_ready", bus.READY, 1);
    chk("abort_done",  bus.DONE,  0);
    rst_n    = 1'b1;
    en_cnt   = 0;
    done_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      en_cnt   += int'(bus.EN);
      done_cnt += int'(bus.DONE);
    end
    chk("abort_no_en",   en_cnt,   0);
    chk("abort_no_done", done_cnt, 0);

    // Back-to-back words with VALID held high.
    @(negedge clk);
    bus.VALID   = 1'b1;
    bus.DATA_IN = 8'h81;
    @(posedge clk);
    spacing = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("b2b_d_first", bus.D, 1);
        bus.DATA_IN = 8'h7E;
      end
      if (c == 25) begin
        chk("b2b_fin_ready", bus.READY, 0);
        chk("b2b_fin_done",  bus.DONE,  1);
      end
      if (bus.READY) begin
        spacing = c;
        break;
      end
    end
    chk("b2b_spacing", spacing, 26);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_d_second", bus.D,    0);
    chk("b2b_busy",     bus.BUSY, 1);
    bus.VALID = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.READY) break;
    end
    chk("b2b_end_ready", bus.READY, 1);
    chk("b2b_end_err",   bus.ERR,   0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/latch_write_sequencer.md
LATCH_WRITE_SEQUENCER -- requirements
Module: latch_write_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of bits serialised per word (legal 2..32).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port DATA_IN  input  WIDTH  parallel word to write into the downstream D latch.
REQ-005 SHALL have port VALID  input  1  DATA_IN offered.
REQ-006 SHALL have port READY  output  1  sequencer can accept a word.
REQ-007 SHALL have port EN  output  1  enable to the downstream latch.
REQ-008 SHALL have port D  output  1  data to the downstream latch.
REQ-009 SHALL have port Q_IN  input  1  Q read back from the downstream latch.
REQ-010 SHALL have port BUSY  output  1  word in progress.
REQ-011 SHALL have port DONE  output  1  one-cycle end-of-word pulse.
REQ-012 SHALL have port ERR  output  1  readback mismatch flag for the last word.

Function
REQ-013 SHALL implement states IDLE, SETUP, STROBE, HOLD, FIN; all outputs registered.
REQ-014 SHALL assert READY only in IDLE; BUSY in SETUP/STROBE/HOLD/FIN.
REQ-015 SHALL accept a word on an edge with state IDLE, VALID=1, and RST_N=1: copy DATA_IN to a shadow register, clear ERR, load bit index WIDTH-1, go to SETUP.
REQ-016 SHALL ignore VALID and DATA_IN changes outside IDLE; the shadow register alone drives D.
REQ-017 SHALL process bits MSB first, three cycles per bit: SETUP (EN=0, D=bit), STROBE (EN=1, D=bit), HOLD (EN=0, D=bit).
REQ-018 SHALL keep D stable across all three phases of a bit; D changes only on entry to SETUP.
REQ-019 SHALL sample Q_IN during HOLD and set ERR if Q_IN differs from the current bit; ERR is sticky until next accept.
REQ-020 SHALL go HOLD->SETUP with index-1 when index>0; HOLD->FIN when index=0 (no wrap of index below 0).
REQ-021 SHALL assert DONE for exactly one cycle in FIN, then go to IDLE; READY returns the cycle after FIN.
REQ-022 SHALL produce exactly WIDTH EN pulses per word, each one cycle wide; EN never high outside STROBE.
REQ-023 Latency: accept edge at cycle 0 -> first SETUP cycle 1 -> DONE high in cycle 3*WIDTH+1 (25 for WIDTH=8).
REQ-024 Minimum accept-to-accept spacing SHALL be 3*WIDTH+2 cycles; VALID held high continuously yields back-to-back words at that spacing.
REQ-025 SHALL hold ERR valid with DONE and keep it until the next accepted word.

Reset
REQ-026 On an edge with RST_N=0: state IDLE, EN=0, D=0, BUSY=0, DONE=0, ERR=0, READY=1, shadow=0, index=0.
REQ-027 Reset mid-word SHALL abort immediately with no further EN pulse and no DONE; reset overrides a simultaneous VALID.
REQ-028 The first accept after reset release SHALL need only RST_N=1 and VALID=1 on that edge.

Verification
REQ-029 Reset with VALID=1, DATA_IN=8'hFF -> next cycle READY=1, EN=0, D=0, BUSY=0, DONE=0, ERR=0; no word accepted.
REQ-030 Accept 8'hA5 with Q_IN tied to a model latch fed by EN/D -> D sequence 1,0,1,0,0,1,0,1 in 3-cycle groups; 8 EN pulses; DONE in cycle 25; ERR=0.
REQ-031 Accept 8'h3C with Q_IN forced 0 -> ERR=1 with DONE (mismatches on bits 5,4,3,2); ERR stays 1 until the next accept.
REQ-032 Change DATA_IN to 8'h00 during a 8'hFF transfer -> D stays 1 for all 24 phase cycles.
REQ-033 Assert RST_N=0 in the STROBE of bit 4 -> EN=0 and BUSY=0 next cycle; no DONE pulse; READY=1.
REQ-034 VALID held high with 8'h81 then 8'h7E -> second accept exactly 26 cycles after the first; READY=0 throughout the FIN cycle.
